// File: rtl/sum_ram_drain_pkg.sv
// Shared definitions for the sum_ram read-side drain controller: default
// parameters, FSM state encoding and the pass-length width helper.
package sum_ram_drain_pkg;

    localparam int DEF_DSIZE      = 24;
    localparam int DEF_ASIZE      = 10;
    localparam int DEF_RD_LAT     = 3;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // A pass may hold 2**asize words, so its length needs one extra bit.
    function automatic int len_width(input int asize);
        return asize + 1;
    endfunction

endpackage

// File: rtl/sum_ram_drain_if.sv
// Downstream result stream of the drain controller.
interface sum_ram_drain_if #(
    parameter int C_DSIZE = sum_ram_drain_pkg::DEF_DSIZE
) ();

    // Handshake: a word transfers on a clock edge where O_valid && I_ready.
    // Once O_valid rises, O_data/O_last stay stable until that transfer, and
    // O_last is meaningful only while O_valid is high.
    logic [C_DSIZE-1:0] O_data;
    logic               O_valid;
    logic               O_last;
    logic               I_ready;

    modport master (output O_data, output O_valid, output O_last, input I_ready);
    modport slave  (input O_data, input O_valid, input O_last, output I_ready);

endinterface

// File: rtl/dly.sv
// Resettable fixed-length shift pipe: dout is din delayed by C_DLY_NUM cycles.
module dly #(
    parameter int C_DLY_NUM = 3,
    parameter int C_DW      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [C_DW-1:0] din,
    output logic [C_DW-1:0] dout
);

    logic [C_DW-1:0] pipe [C_DLY_NUM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C_DLY_NUM; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < C_DLY_NUM; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[C_DLY_NUM-1];

endmodule

// File: rtl/sum_ram_drain_fifo.sv
// First-word fall-through synchronous FIFO (power-of-two depth) with occupancy count.
module sync_fifo_fwft #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 25
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The upstream credit scheme must never push into a full FIFO.
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/sum_ram_drain.sv
// Read-side controller for the ping-pong sum RAM: swaps banks per pass, reads the
// finished bank through the shared read port and streams it out with backpressure.
module sum_ram_drain
    import sum_ram_drain_pkg::*;
#(
    parameter int C_DSIZE      = DEF_DSIZE,
    parameter int C_ASIZE      = DEF_ASIZE,
    parameter int C_RD_LAT     = DEF_RD_LAT,
    parameter int C_FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    input  logic                 I_pass_done,
    input  logic [C_ASIZE:0]     I_len,
    input  logic                 I_dven,
    output logic                 O_wram0_en,
    output logic                 O_busy,
    output logic [C_ASIZE-1:0]   O_raddr,
    input  logic [C_DSIZE-1:0]   I_rdata,
    output logic                 O_done,
    output logic                 O_err,
    output state_t               O_state,
    sum_ram_drain_if.master      out
);

    localparam int C_LEN_W = len_width(C_ASIZE);
    localparam int C_CW    = $clog2(C_FIFO_DEPTH) + 1;

    state_t               state;
    state_t               state_nxt;
    logic [C_LEN_W-1:0]   len_q;
    logic [C_LEN_W-1:0]   rd_cnt;
    logic [C_ASIZE-1:0]   raddr_q;
    logic [C_CW-1:0]      inflight;
    logic [C_CW-1:0]      fifo_count;
    logic                 accept;
    logic                 credit_ok;
    logic                 issue;
    logic                 issue_last;
    logic                 flush_ok;
    logic [1:0]           pipe_out;
    logic                 fifo_empty;
    logic                 pop;
    logic [C_DSIZE:0]     fifo_rdata;

    assign accept     = (state == IDLE) && I_pass_done;
    // Queued words plus words still coming back from the RAM must fit in the FIFO.
    assign credit_ok  = (int'(fifo_count) + int'(inflight)) < C_FIFO_DEPTH;
    assign issue      = (state == DRAIN) && !I_dven && credit_ok;
    assign issue_last = issue && (rd_cnt == len_q - C_LEN_W'(1));
    assign flush_ok   = (state == FLUSH) && (inflight == '0) && fifo_empty;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (I_pass_done) state_nxt = (I_len == '0) ? FLUSH : DRAIN;
            DRAIN:   if (issue_last)  state_nxt = FLUSH;
            FLUSH:   if (flush_ok)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_wram0_en <= 1'b1;
            len_q      <= '0;
            rd_cnt     <= '0;
            raddr_q    <= '0;
            O_err      <= 1'b0;
            inflight   <= '0;
        end else begin
            if (accept) begin
                O_wram0_en <= !O_wram0_en;
                len_q      <= I_len;
                rd_cnt     <= '0;
            end
            if (I_pass_done && (state != IDLE)) O_err <= 1'b1;
            if (issue) begin
                rd_cnt  <= rd_cnt + 1'b1;
                raddr_q <= rd_cnt[C_ASIZE-1:0];
            end
            case ({issue, pipe_out[1]})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Between reads the address parks on the last one issued.
    assign O_raddr = issue ? rd_cnt[C_ASIZE-1:0] : raddr_q;
    assign O_busy  = (state != IDLE);
    assign O_done  = flush_ok;
    assign O_state = state;

    dly #(
        .C_DLY_NUM (C_RD_LAT),
        .C_DW      (2)
    ) u_rd_pipe (
        .clk   (I_clk),
        .rst_n (I_rst_n),
        .din   ({issue, issue_last}),
        .dout  (pipe_out)
    );

    sync_fifo_fwft #(
        .DEPTH (C_FIFO_DEPTH),
        .WIDTH (C_DSIZE + 1)
    ) u_fifo (
        .clk   (I_clk),
        .rst_n (I_rst_n),
        .push  (pipe_out[1]),
        .wdata ({pipe_out[0], I_rdata}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign pop         = out.O_valid && out.I_ready;
    assign out.O_valid = !fifo_empty;
    assign out.O_data  = fifo_empty ? '0 : fifo_rdata[C_DSIZE-1:0];
    assign out.O_last  = !fifo_empty && fifo_rdata[C_DSIZE];

endmodule

// File: tb/tb_sum_ram_drain.sv
// Directed bench for sum_ram_drain with a 3-cycle sum_ram read model and a
// scoreboard queue of expected {last, data} words.
module tb_sum_ram_drain;
    import sum_ram_drain_pkg::*;

    localparam int W = 24;
    localparam int A = 10;

    logic           clk;
    logic           rst_n;
    logic           pass_done;
    logic [A:0]     len_i;
    logic           dven;
    logic           wram0_en;
    logic           busy;
    logic [A-1:0]   raddr;
    logic [W-1:0]   rdata;
    logic           done;
    logic           err;
    state_t         st;

    sum_ram_drain_if #(.C_DSIZE(W)) s ();

    sum_ram_drain dut (
        .I_clk       (clk),
        .I_rst_n     (rst_n),
        .I_pass_done (pass_done),
        .I_len       (len_i),
        .I_dven      (dven),
        .O_wram0_en  (wram0_en),
        .O_busy      (busy),
        .O_raddr     (raddr),
        .I_rdata     (rdata),
        .O_done      (done),
        .O_err       (err),
        .O_state     (st),
        .out         (s)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sum_ram read model: address register, RAM, output register
    logic [A-1:0] a1, a2, a3;
    logic [13:0]  seed;
    always @(posedge clk) begin
        a1 <= raddr;
        a2 <= a1;
        a3 <= a2;
    end
    assign rdata = {seed, a3};

    // scoreboard
    logic [W:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         beat_cnt = 0;
    bit         exp_wram = 1'b1;
    bit         stalled_prev = 1'b0;
    logic [W:0] held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev)
                check("stall_hold", {s.O_valid, s.O_last, s.O_data}, {1'b1, held});
            if (s.O_valid && s.I_ready) begin
                beat_cnt++;
                if (exp_q.size() == 0) check("beat_avail", 32'(exp_q.size()), 1);
                else check("beat", {s.O_last, s.O_data}, exp_q.pop_front());
            end
            stalled_prev = s.O_valid && !s.I_ready;
            held = {s.O_last, s.O_data};
        end
    end

    // driver tasks
    task automatic start_pass(input int len);
        seed = 14'($urandom_range(0, 16383));
        pass_done = 1'b1;
        len_i = 11'(len);
        for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), seed, 10'(i)});
        exp_wram = !exp_wram;
        @(posedge clk); #1;
        pass_done = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input bit throttle, input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            s.I_ready = throttle ? (c % 3 == 0) : 1'b1;
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        s.I_ready = 1'b1;
        check({tag, "_done"}, 32'(seen), 1);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wram0"}, wram0_en, 1);
        check({tag, "_raddr"}, raddr, 0);
        check({tag, "_valid"}, s.O_valid, 0);
        check({tag, "_last"},  s.O_last, 0);
        check({tag, "_data"},  s.O_data, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_err"},   err, 0);
        check({tag, "_state"}, st, IDLE);
    endtask

    initial begin
        int base;
        bit reached;
        rst_n = 1'b0; pass_done = 1'b0; len_i = '0; dven = 1'b0; s.I_ready = 1'b1;
        seed = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: len=4, free-running output
        @(posedge clk); #1;
        start_pass(4);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("t1_wram0", wram0_en, 0);
            check("t1_raddr", raddr, (k <= 4) ? k - 1 : 3);
            check("t1_valid", s.O_valid, (k >= 5 && k <= 8));
            check("t1_last",  s.O_last, (k == 8));
            check("t1_done",  done, (k == 9));
            check("t1_busy",  busy, (k <= 9));
            @(posedge clk); #1;
        end
        check("t1_drained", exp_q.size(), 0);

        // 2: len=16 with downstream ready one cycle in three
        start_pass(16);
        run_until_done(120, 1'b1, "t2");

        // 3: len=8 with the accumulator holding the read port for 5 cycles
        start_pass(8);
        @(negedge clk); check("t3_raddr0", raddr, 0);
        @(posedge clk); #1;
        @(negedge clk); check("t3_raddr1", raddr, 1);
        @(posedge clk); #1;
        dven = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); check("t3_frozen", raddr, 1);
            @(posedge clk); #1;
        end
        dven = 1'b0;
        @(negedge clk); check("t3_resume", raddr, 2);
        @(posedge clk); #1;
        base = beat_cnt;
        run_until_done(60, 1'b0, "t3");
        check("t3_beats", beat_cnt - base, 6);

        // 4: empty pass
        start_pass(0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t4_wram0", wram0_en, exp_wram);
            check("t4_valid", s.O_valid, 0);
            check("t4_done",  done, (k == 1));
            check("t4_busy",  busy, (k == 1));
            @(posedge clk); #1;
        end

        // 5: premature pass_done while draining
        base = beat_cnt;
        start_pass(12);
        @(posedge clk); #1;
        @(posedge clk); #1;
        pass_done = 1'b1; len_i = 11'd5;
        @(posedge clk); #1;
        pass_done = 1'b0;
        @(negedge clk);
        check("t5_err",   err, 1);
        check("t5_wram0", wram0_en, exp_wram);
        check("t5_busy",  busy, 1);
        @(posedge clk); #1;
        run_until_done(60, 1'b0, "t5");
        check("t5_beats", beat_cnt - base, 12);
        check("t5_err_sticky", err, 1);

        // 6: reset at beat 3 of a len=10 pass, then a clean len=2 pass
        base = beat_cnt;
        reached = 1'b0;
        start_pass(10);
        for (int c = 0; c < 40 && !reached; c++) begin
            @(posedge clk); #1;
            if (beat_cnt - base >= 3) reached = 1'b1;
        end
        check("t6_beat3", 32'(reached), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        exp_q.delete();
        exp_wram = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        base = beat_cnt;
        start_pass(2);
        run_until_done(30, 1'b0, "t6");
        check("t6_beats", beat_cnt - base, 2);
        check("t6_wram0", wram0_en, 0);

        // 7: full-size pass exercises the address wrap
        base = beat_cnt;
        start_pass(1024);
        run_until_done(1100, 1'b0, "t7");
        check("t7_beats", beat_cnt - base, 1024);
        check("t7_raddr_end", raddr, 1023);
        check("t7_wram0", wram0_en, exp_wram);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
